// File: rtl/rst_seq_pkg.sv
// Shared types and defaults for the clk_100 reset sequencer.
package rst_seq_pkg;

  typedef enum logic [2:0] {HOLD, WAIT, GAP, RUN, FAIL, FAULT} state_e;

  localparam int NSTAGE_DEF      = 3;
  localparam int HOLD_CYC_DEF    = 100;
  localparam int GAP_CYC_DEF     = 16;
  localparam int TIMEOUT_CYC_DEF = 1_000_000;
  localparam int MAX_RETRY_DEF   = 3;
  localparam int SEC_CYC_DEF     = 100_000_000;
  localparam int TIMER_W         = 32;

  // Width of a stage index; never narrower than one bit.
  function automatic int stage_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rst_seq_timer.sv
// Loadable up-counter with synchronous clear and a terminal-count compare.
// Holds at the terminal value (or all-ones) instead of wrapping.
module rst_seq_timer #(
  parameter int W = 32
) (
  input  logic         clk_100,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic [W-1:0] term,
  output logic [W-1:0] cnt,
  output logic         hit
);

  assign hit = (cnt == term);

  always_ff @(posedge clk_100) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (!hit && (cnt != '1)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/rst_seq_ctrl.sv
// Staged reset sequencer: holds all subsystem resets, then releases them in
// index order, gated by each stage's done flag, with timeout and retry.
// Optional periodic restart in RUN is enabled by defining RST_SEQ_PERIODIC_EN.
module rst_seq_ctrl
  import rst_seq_pkg::*;
#(
  parameter int NSTAGE      = NSTAGE_DEF,
  parameter int HOLD_CYC    = HOLD_CYC_DEF,
  parameter int GAP_CYC     = GAP_CYC_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter int MAX_RETRY   = MAX_RETRY_DEF,
  parameter int SEC_CYC     = SEC_CYC_DEF
) (
  input  logic                       clk_100,
  input  logic                       rst_n,
  input  logic                       soft_req,
  input  logic [1:0]                 mode,
  input  logic [NSTAGE-1:0]          stage_done,
  output logic [NSTAGE-1:0]          rst_out_n,
  output logic                       busy,
  output logic                       all_ready,
  output logic                       timeout_err,
  output logic [stage_w(NSTAGE)-1:0] fail_stage,
  output logic [1:0]                 retry_cnt
);

  localparam int SW = stage_w(NSTAGE);
  localparam logic [SW-1:0] LAST = SW'(NSTAGE - 1);

  state_e              state, state_nx;
  logic [SW-1:0]       k, k_nx;
  logic [NSTAGE-1:0]   rst_nx;
  logic                terr_nx;
  logic [SW-1:0]       fs_nx;
  logic [1:0]          rc_nx;
  logic                tmr_clr, tmr_hit, per_force;
  logic [TIMER_W-1:0]  tmr_term, unused_tmr_cnt;

  function automatic logic [SW-1:0] lowest_zero(input logic [NSTAGE-1:0] v);
    logic [SW-1:0] idx;
    idx = '0;
    for (int i = NSTAGE - 1; i >= 0; i--) begin
      if (!v[i]) idx = SW'(i);
    end
    return idx;
  endfunction

  function automatic logic [1:0] bump(input logic [1:0] c);
    return (c == 2'b11) ? c : c + 2'd1;
  endfunction

  always_comb begin
    tmr_term = '1;
    case (state)
      HOLD:    tmr_term = TIMER_W'(HOLD_CYC - 1);
      WAIT:    tmr_term = TIMER_W'(TIMEOUT_CYC - 1);
      GAP:     tmr_term = TIMER_W'(GAP_CYC - 1);
      default: tmr_term = '1;
    endcase
  end

  // Timer restarts on every state entry, including a soft restart from HOLD.
  assign tmr_clr = soft_req || (state_nx != state);

  rst_seq_timer #(.W(TIMER_W)) u_state_tmr (
    .clk_100  (clk_100),
    .rst_n    (rst_n),
    .clr      (tmr_clr),
    .load     (1'b0),
    .load_val ('0),
    .term     (tmr_term),
    .cnt      (unused_tmr_cnt),
    .hit      (tmr_hit)
  );

`ifdef RST_SEQ_PERIODIC_EN
  logic [TIMER_W-1:0] per_term, unused_per_cnt;
  logic               per_hit;

  // Interval is latched on RUN entry so mode changes only apply next time.
  always_ff @(posedge clk_100) begin
    if (!rst_n) begin
      per_term <= '0;
    end else if ((state_nx == RUN) && (state != RUN)) begin
      per_term <= TIMER_W'((3 + int'(mode)) * SEC_CYC - 1);
    end
  end

  rst_seq_timer #(.W(TIMER_W)) u_per_tmr (
    .clk_100  (clk_100),
    .rst_n    (rst_n),
    .clr      (state != RUN),
    .load     (1'b0),
    .load_val ('0),
    .term     (per_term),
    .cnt      (unused_per_cnt),
    .hit      (per_hit)
  );

  assign per_force = (state == RUN) && per_hit;
`else
  logic unused_cfg;
  assign unused_cfg = ^{mode, TIMER_W'(SEC_CYC)};
  assign per_force  = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    k_nx     = k;
    rst_nx   = rst_out_n;
    terr_nx  = timeout_err;
    fs_nx    = fail_stage;
    rc_nx    = retry_cnt;
    if (soft_req) begin
      state_nx = HOLD;
      k_nx     = '0;
      rst_nx   = '0;
      terr_nx  = 1'b0;
      rc_nx    = '0;
    end else begin
      case (state)
        HOLD: begin
          rst_nx = '0;
          if (tmr_hit) begin
            state_nx  = WAIT;
            k_nx      = '0;
            rst_nx[0] = 1'b1;
          end
        end
        WAIT: begin
          if (stage_done[k]) begin
            state_nx = (k == LAST) ? RUN : GAP;
          end else if (tmr_hit) begin
            state_nx = FAIL;
            terr_nx  = 1'b1;
            fs_nx    = k;
            rc_nx    = bump(retry_cnt);
          end
        end
        GAP: begin
          if (tmr_hit) begin
            state_nx     = WAIT;
            k_nx         = k + SW'(1);
            rst_nx[k_nx] = 1'b1;
          end
        end
        RUN: begin
          if (!(&stage_done)) begin
            state_nx = FAIL;
            terr_nx  = 1'b1;
            fs_nx    = lowest_zero(stage_done);
            rc_nx    = bump(retry_cnt);
          end else if (per_force) begin
            state_nx = HOLD;
            k_nx     = '0;
            rst_nx   = '0;
            rc_nx    = '0;
          end
        end
        FAIL: begin
          rst_nx   = '0;
          state_nx = (32'(retry_cnt) < MAX_RETRY) ? HOLD : FAULT;
        end
        FAULT: begin
          rst_nx = '0;
        end
        default: begin
          state_nx = HOLD;
          rst_nx   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_100) begin
    if (!rst_n) begin
      state       <= HOLD;
      k           <= '0;
      rst_out_n   <= '0;
      timeout_err <= 1'b0;
      fail_stage  <= '0;
      retry_cnt   <= '0;
    end else begin
      state       <= state_nx;
      k           <= k_nx;
      rst_out_n   <= rst_nx;
      timeout_err <= terr_nx;
      fail_stage  <= fs_nx;
      retry_cnt   <= rc_nx;
    end
  end

  assign busy      = (state != RUN);
  assign all_ready = (state == RUN);

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Directed bench for rst_seq_ctrl: power-up, drop in RUN, timeout/retry/FAULT,
// FAULT recovery, soft_req/timeout collision and RUN duration.
module tb_rst_seq_ctrl;

  localparam int NSTAGE = 3;
  localparam int SW     = 2;

  logic              clk_100 = 1'b0;
  logic              rst_n;
  logic              soft_req;
  logic [1:0]        mode;
  logic [NSTAGE-1:0] stage_done;
  logic [NSTAGE-1:0] rst_out_n;
  logic              busy, all_ready, timeout_err;
  logic [SW-1:0]     fail_stage;
  logic [1:0]        retry_cnt;

  logic [NSTAGE-1:0] dn_en;
  logic [7:0]        dcnt [NSTAGE];
  int                now;
  int                n_chk = 0;
  int                n_fail = 0;

  always #5 clk_100 = ~clk_100;

  rst_seq_ctrl #(
    .NSTAGE(3), .HOLD_CYC(100), .GAP_CYC(16), .TIMEOUT_CYC(50),
    .MAX_RETRY(3), .SEC_CYC(1000)
  ) dut (
    .clk_100     (clk_100),
    .rst_n       (rst_n),
    .soft_req    (soft_req),
    .mode        (mode),
    .stage_done  (stage_done),
    .rst_out_n   (rst_out_n),
    .busy        (busy),
    .all_ready   (all_ready),
    .timeout_err (timeout_err),
    .fail_stage  (fail_stage),
    .retry_cnt   (retry_cnt)
  );

  // Subsystem stand-in: done rises 10 cycles after its reset is released.
  always @(posedge clk_100) begin
    for (int s = 0; s < NSTAGE; s++) begin
      if (!rst_out_n[s]) dcnt[s] <= 8'd0;
      else if (dcnt[s] != 8'hFF) dcnt[s] <= dcnt[s] + 8'd1;
    end
  end

  always_comb begin
    stage_done = '0;
    for (int s = 0; s < NSTAGE; s++) stage_done[s] = dn_en[s] && (dcnt[s] >= 8'd10);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", tag, now, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_100);
    now++;
  endtask

  task automatic goto(input int c);
    while (now < c) tick();
  endtask

  task automatic pulse_soft(input int c);
    goto(c);
    soft_req = 1'b1;
    tick();
    soft_req = 1'b0;
  endtask

  initial begin
    rst_n    = 1'b0;
    soft_req = 1'b0;
    mode     = 2'd1;
    dn_en    = '1;
    now      = 0;
    repeat (3) @(posedge clk_100);
    #1 rst_n = 1'b1;
    @(negedge clk_100);
    now = 0;

    // Reset state and power-up release schedule
    chk("rst_out_n_reset", 32'(rst_out_n), 32'h0);
    chk("busy_reset", 32'(busy), 32'd1);
    chk("all_ready_reset", 32'(all_ready), 32'd0);
    chk("timeout_err_reset", 32'(timeout_err), 32'd0);
    chk("fail_stage_reset", 32'(fail_stage), 32'd0);
    chk("retry_cnt_reset", 32'(retry_cnt), 32'd0);
    goto(99);  chk("pu_hold_end", 32'(rst_out_n), 32'b000);
    goto(100); chk("pu_rel0", 32'(rst_out_n), 32'b001);
    goto(126); chk("pu_gap0_end", 32'(rst_out_n), 32'b001);
    goto(127); chk("pu_rel1", 32'(rst_out_n), 32'b011);
    goto(153); chk("pu_gap1_end", 32'(rst_out_n), 32'b011);
    goto(154); chk("pu_rel2", 32'(rst_out_n), 32'b111);
    goto(164); chk("pu_not_ready", 32'(all_ready), 32'd0);
    goto(165); chk("pu_ready", 32'(all_ready), 32'd1);
    chk("pu_busy", 32'(busy), 32'd0);

    // Drop of stage 2 while in RUN
    goto(170); dn_en[2] = 1'b0;
    goto(171);
    chk("drop_fail_stage", 32'(fail_stage), 32'd2);
    chk("drop_terr", 32'(timeout_err), 32'd1);
    chk("drop_retry", 32'(retry_cnt), 32'd1);
    chk("drop_ready_low", 32'(all_ready), 32'd0);
    goto(172);
    chk("drop_hold_rst", 32'(rst_out_n), 32'b000);
    chk("drop_hold_busy", 32'(busy), 32'd1);
    dn_en[2] = 1'b1;
    goto(271); chk("re_hold_end", 32'(rst_out_n), 32'b000);
    goto(272); chk("re_rel0", 32'(rst_out_n), 32'b001);
    goto(337);
    chk("re_ready", 32'(all_ready), 32'd1);
    chk("re_retry_kept", 32'(retry_cnt), 32'd1);
    chk("re_terr_sticky", 32'(timeout_err), 32'd1);

    // Timeout on stage 1, three times, into FAULT
    pulse_soft(340);
    dn_en[1] = 1'b0;
    goto(341);
    chk("soft_clr_retry", 32'(retry_cnt), 32'd0);
    chk("soft_clr_terr", 32'(timeout_err), 32'd0);
    chk("soft_hold_rst", 32'(rst_out_n), 32'b000);
    goto(468); chk("to_rel1", 32'(rst_out_n), 32'b011);
    goto(517); chk("to_not_yet", 32'(timeout_err), 32'd0);
    goto(518);
    chk("to_terr", 32'(timeout_err), 32'd1);
    chk("to_fail_stage", 32'(fail_stage), 32'd1);
    chk("to_retry1", 32'(retry_cnt), 32'd1);
    goto(519); chk("to_hold_rst", 32'(rst_out_n), 32'b000);
    goto(696); chk("to_retry2", 32'(retry_cnt), 32'd2);
    goto(874); chk("to_retry3", 32'(retry_cnt), 32'd3);
    goto(875);
    chk("fault_rst", 32'(rst_out_n), 32'b000);
    chk("fault_busy", 32'(busy), 32'd1);
    goto(975);
    chk("fault_stays_rst", 32'(rst_out_n), 32'b000);
    chk("fault_stays_busy", 32'(busy), 32'd1);

    // Recovery from FAULT
    dn_en[1] = 1'b1;
    pulse_soft(980);
    chk("rec_retry", 32'(retry_cnt), 32'd0);
    chk("rec_terr", 32'(timeout_err), 32'd0);
    goto(1081); chk("rec_rel0", 32'(rst_out_n), 32'b001);
    goto(1135); chk("rec_rel2", 32'(rst_out_n), 32'b111);
    goto(1146); chk("rec_ready", 32'(all_ready), 32'd1);

    // soft_req coinciding with the timeout terminal count
    dn_en[1] = 1'b0;
    pulse_soft(1150);
    goto(1278); chk("col_rel1", 32'(rst_out_n), 32'b011);
    goto(1327);
    chk("col_pre_terr", 32'(timeout_err), 32'd0);
    soft_req = 1'b1;
    tick();
    soft_req = 1'b0;
    dn_en[1] = 1'b1;
    chk("col_terr", 32'(timeout_err), 32'd0);
    chk("col_retry", 32'(retry_cnt), 32'd0);
    chk("col_hold_rst", 32'(rst_out_n), 32'b000);
    chk("col_busy", 32'(busy), 32'd1);
    goto(1427); chk("col_hold_end", 32'(rst_out_n), 32'b000);
    goto(1428); chk("col_rel0", 32'(rst_out_n), 32'b001);
    goto(1492); chk("col_not_ready", 32'(all_ready), 32'd0);
    goto(1493); chk("col_ready", 32'(all_ready), 32'd1);

`ifdef RST_SEQ_PERIODIC_EN
    goto(5492);
    chk("per_last_run", 32'(all_ready), 32'd1);
    chk("per_last_rst", 32'(rst_out_n), 32'b111);
    goto(5493);
    chk("per_restart_ready", 32'(all_ready), 32'd0);
    chk("per_restart_rst", 32'(rst_out_n), 32'b000);
`else
    goto(11493);
    chk("run_persist_ready", 32'(all_ready), 32'd1);
    chk("run_persist_rst", 32'(rst_out_n), 32'b111);
    chk("run_persist_busy", 32'(busy), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
